// File: rtl/usb_fs_bulk_in_ep.sv
// usb_fs_bulk_in_ep: bulk IN endpoint that queues a user byte stream and hands it to the
// USB FS engine one packet at a time, waiting for the host ACK between packets.
module usb_fs_bulk_in_ep #(
    parameter int MAX_PKT       = 64,
    parameter int FIFO_DEPTH    = 128,
    parameter int FLUSH_TIMEOUT = 48000,
    localparam int CL           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    input  logic          flush,
    input  logic          stall_req,
    output logic [CL-1:0] fifo_level,
    output logic          busy,
    output logic          in_ep_req,
    input  logic          in_ep_grant,
    input  logic          in_ep_data_free,
    output logic          in_ep_data_put,
    output logic [7:0]    in_ep_data,
    output logic          in_ep_data_done,
    output logic          in_ep_stall,
    input  logic          in_ep_acked
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_PKT + 1);
    localparam int TW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, REQ, XFER, DONE, WAIT_ACK} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CL-1:0] r_level;
    logic [LW-1:0] r_len, r_sent;
    logic [TW-1:0] r_timer;
    logic          r_flush_pend, r_last_full, r_req, r_done, r_stall;
    logic          w_wr, w_rd, w_full_pkt, w_short, w_tick, w_tmo;

    assign wr_ready   = r_level != CL'(FIFO_DEPTH);
    assign w_wr       = wr_valid && wr_ready;
    assign w_rd       = r_state == XFER && in_ep_grant && in_ep_data_free && r_sent < r_len;
    assign w_full_pkt = r_level >= CL'(MAX_PKT);
    // A flushed transfer that ended on a full packet still owes the host a ZLP.
    assign w_short    = r_flush_pend && (r_level != '0 || r_last_full);
    assign w_tick     = r_state == IDLE && r_level != '0 && !w_full_pkt && !r_flush_pend;
    assign w_tmo      = FLUSH_TIMEOUT != 0 && w_tick && !w_wr && r_timer == TW'(FLUSH_TIMEOUT);

    assign fifo_level      = r_level;
    assign busy            = r_state != IDLE;
    assign in_ep_req       = r_req;
    assign in_ep_data_put  = w_rd;
    assign in_ep_data      = r_level != '0 ? r_mem[r_rptr] : 8'h00;
    assign in_ep_data_done = r_done;
    assign in_ep_stall     = r_stall;

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wptr] <= wr_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + CL'(w_wr) - CL'(w_rd);
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_sent       <= '0;
            r_timer      <= '0;
            r_flush_pend <= 1'b0;
            r_last_full  <= 1'b0;
            r_req        <= 1'b0;
            r_done       <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_stall <= stall_req;
            r_done  <= 1'b0;
            r_timer <= (w_wr || !w_tick) ? '0 : r_timer + 1'b1;
            if (flush || w_tmo) r_flush_pend <= 1'b1;
            case (r_state)
                IDLE:
                    if (w_full_pkt) begin
                        r_len   <= LW'(MAX_PKT);
                        r_sent  <= '0;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end else if (w_short) begin
                        r_len        <= LW'(r_level);
                        r_sent       <= '0;
                        r_req        <= 1'b1;
                        r_state      <= REQ;
                        r_flush_pend <= flush;
                    end else if (r_flush_pend) begin
                        r_flush_pend <= flush;
                    end
                REQ:
                    if (in_ep_grant) begin
                        r_state <= r_len == '0 ? DONE : XFER;
                        r_done  <= r_len == '0;
                    end
                XFER:
                    if (w_rd) begin
                        r_sent <= r_sent + 1'b1;
                        if (r_sent == r_len - 1'b1) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                DONE: begin
                    r_req   <= 1'b0;
                    r_state <= WAIT_ACK;
                end
                WAIT_ACK:
                    if (in_ep_acked) begin
                        r_last_full <= r_len == LW'(MAX_PKT);
                        r_state     <= IDLE;
                    end
                default: r_state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_usb_fs_bulk_in_ep.sv
// tb_usb_fs_bulk_in_ep: directed vectors for the bulk IN endpoint with a byte-queue model
// of the expected packet contents.
module tb_usb_fs_bulk_in_ep;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic       stall_req = 1'b0;
    logic [7:0] fifo_level;
    logic       busy;
    logic       in_ep_req;
    logic       in_ep_grant = 1'b0;
    logic       in_ep_data_free = 1'b1;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked = 1'b0;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] byte_ctr = 8'h00;
    logic [7:0] q[$];

    typedef struct {
        int nbytes;
        bit do_flush;
        bit toggle;
        int len0;
        int len1;
    } vec_t;
    vec_t vecs[5];

    usb_fs_bulk_in_ep #(.MAX_PKT(64), .FIFO_DEPTH(128), .FLUSH_TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .flush(flush), .stall_req(stall_req), .fifo_level(fifo_level), .busy(busy),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
        .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = byte_ctr;
            #1;
            if (wr_ready) begin
                q.push_back(byte_ctr);
                byte_ctr++;
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic do_packet(input int exp_len, input bit toggle);
        int puts, first_n, last_n, done_n, bad, req_in_done;
        bit seen;
        puts = 0; first_n = -1; last_n = -1; done_n = -1; bad = 0; req_in_done = 0; seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = in_ep_req;
        end
        check("req_rise", int'(seen), 1);
        if (!seen) return;
        in_ep_grant = 1'b1;
        for (int n = 0; n < 400 && done_n < 0; n++) begin
            @(negedge clk);
            in_ep_data_free = toggle ? (n % 2 == 1) : 1'b1;
            #1;
            if (in_ep_data_put) begin
                if (first_n < 0) first_n = n;
                last_n = n;
                puts++;
                if (!in_ep_data_free || !in_ep_req) bad++;
                check("data", int'(in_ep_data), q.size() > 0 ? int'(q.pop_front()) : -1);
            end
            if (in_ep_data_done) begin
                done_n = n;
                req_in_done = int'(in_ep_req);
            end
        end
        check("done_seen", int'(done_n >= 0), 1);
        check("put_count", puts, exp_len);
        check("put_gated", bad, 0);
        check("req_in_done", req_in_done, 1);
        if (exp_len > 0) check("done_after_last_put", done_n - last_n, 1);
        if (!toggle && exp_len > 0) check("puts_back_to_back", last_n - first_n + 1, exp_len);
        in_ep_grant = 1'b0;
        in_ep_data_free = 1'b1;
        @(negedge clk);
        #1;
        check("done_one_cycle", int'(in_ep_data_done), 0);
        check("req_drop_wait_ack", int'(in_ep_req), 0);
        check("busy_wait_ack", int'(busy), 1);
        repeat (3) @(negedge clk);
        #1;
        check("no_launch_before_ack", int'(in_ep_req), 0);
        @(negedge clk);
        in_ep_acked = 1'b1;
        @(negedge clk);
        in_ep_acked = 1'b0;
    endtask

    task automatic idle_check();
        bit seen;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (in_ep_req) seen = 1;
        end
        check("no_extra_packet", int'(seen), 0);
        check("level_empty", int'(fifo_level), 0);
        check("idle", int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{64, 1'b0, 1'b0, 64, -1};
        vecs[1] = '{5,  1'b1, 1'b0, 5,  -1};
        vecs[2] = '{64, 1'b1, 1'b0, 64, 0};
        vecs[3] = '{64, 1'b0, 1'b1, 64, -1};
        vecs[4] = '{70, 1'b1, 1'b0, 64, 6};

        repeat (3) @(negedge clk);
        #1;
        check("rst_req", int'(in_ep_req), 0);
        check("rst_wr_ready", int'(wr_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_level", int'(fifo_level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(in_ep_data_done), 0);
        check("rst_put", int'(in_ep_data_put), 0);

        for (int v = 0; v < 5; v++) begin
            write_bytes(vecs[v].nbytes);
            if (vecs[v].do_flush) pulse_flush();
            do_packet(vecs[v].len0, vecs[v].toggle);
            if (vecs[v].len1 >= 0) do_packet(vecs[v].len1, vecs[v].toggle);
            idle_check();
        end

        // stall is a pure one-cycle-delayed copy
        @(negedge clk);
        stall_req = 1'b1;
        #1;
        check("stall_latency", int'(in_ep_stall), 0);
        @(negedge clk);
        #1;
        check("stall_on", int'(in_ep_stall), 1);
        check("stall_no_fsm", int'(busy), 0);
        stall_req = 1'b0;
        @(negedge clk);
        #1;
        check("stall_off", int'(in_ep_stall), 0);

        // timeout: 3 bytes, restart the count with a 4th byte 50 cycles later
        begin
            int cnt;
            bit seen;
            write_bytes(3);
            repeat (49) @(negedge clk);
            #1;
            check("tmo_early_req", int'(in_ep_req), 0);
            check("tmo_level", int'(fifo_level), 3);
            write_bytes(1);
            cnt = 0; seen = 0;
            for (int n = 0; n < 300 && !seen; n++) begin
                @(negedge clk);
                #1;
                cnt++;
                seen = in_ep_req;
            end
            check("tmo_fired", int'(seen), 1);
            check("tmo_window", int'(cnt >= 100 && cnt <= 106), 1);
            do_packet(4, 1'b0);
            idle_check();
        end

        // reset in the middle of a packet
        begin
            int puts;
            bit seen;
            write_bytes(64);
            seen = 0;
            for (int n = 0; n < 300 && !seen; n++) begin
                @(negedge clk);
                #1;
                seen = in_ep_req;
            end
            check("rst_mid_req", int'(seen), 1);
            in_ep_grant = 1'b1;
            puts = 0;
            for (int n = 0; n < 100 && puts < 10; n++) begin
                @(negedge clk);
                #1;
                if (in_ep_data_put) puts++;
            end
            check("rst_mid_puts", puts, 10);
            reset = 1'b1;
            #1;
            check("rst_mid_req_low", int'(in_ep_req), 0);
            check("rst_mid_put_low", int'(in_ep_data_put), 0);
            check("rst_mid_level", int'(fifo_level), 0);
            check("rst_mid_busy", int'(busy), 0);
            check("rst_mid_data", int'(in_ep_data), 0);
            check("rst_mid_wr_ready", int'(wr_ready), 1);
            q.delete();
            in_ep_grant = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            write_bytes(64);
            do_packet(64, 1'b0);
            idle_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
